synapse_accum: RTL

Read-side sequencer and accumulator that sits directly downstream of the synaptic-weight RAM in the SNN datapath. On `start` it latches one time-step's input spike vector and sweeps the weight RAM neuron by neuron, one word per cycle. For each neuron it sums the signed weights of all spiking inputs with saturation. Each neuron's total is emitted as a one-cycle result for the membrane-potential/neuron stage.

---
 rtl/synapse_accum.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/synapse_accum.sv
// Weight-RAM read sequencer and per-neuron saturating accumulator.
// One start sweeps all NUM_NEURONS x NUM_INPUTS weights, emitting one sum per neuron.
module synapse_accum #(
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_NEURONS = 10,
  parameter int POT_WIDTH   = 32,
  parameter int BASE_ADDR   = 0,
  localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_INPUTS-1:0] input_spikes,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wen,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy,
  output logic                  sum_valid,
  output logic [NW-1:0]         sum_neuron,
  output logic [POT_WIDTH-1:0]  sum_data,
  output logic                  done
);

  localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [IW-1:0]         IN_LAST = IW'(NUM_INPUTS - 1);
  localparam logic [NW-1:0]         N_LAST  = NW'(NUM_NEURONS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);
  localparam bit                    SINGLE  = (NUM_INPUTS * NUM_NEURONS == 1);

  // Handshake: start is a level sampled on a clock edge and accepted only in IDLE;
  // sum_valid and done are single-cycle pulses with no back-pressure.
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [NUM_INPUTS-1:0] spk_q;
  logic [IW-1:0]         in_cnt, in_nxt;
  logic [NW-1:0]         n_cnt, n_nxt;
  logic                  issue_last, accept, drain_done;

  // Stage A describes the address currently on ram_addr; stage T lines up with ram_dout.
  logic                  a_v;
  logic                  t_v, t_spk, t_last;
  logic [NW-1:0]         t_n;

  logic [POT_WIDTH-1:0]  acc, acc_add, acc_new;
  logic [POT_WIDTH:0]    sum_w;

  assign ram_wen = 1'b0;

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    drain_done = 1'b0;
    in_nxt     = (in_cnt == IN_LAST) ? '0 : in_cnt + IW'(1);
    n_nxt      = (in_cnt == IN_LAST) ? n_cnt + NW'(1) : n_cnt;
    issue_last = (in_nxt == IN_LAST) && (n_nxt == N_LAST);
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SINGLE ? DRAIN : FETCH;
        end
      end
      FETCH: begin
        if (issue_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!a_v && !t_v) begin
          drain_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // One extra sign bit is enough to detect overflow of a single add.
  always_comb begin
    sum_w = {acc[POT_WIDTH-1], acc}
          + {{(POT_WIDTH + 1 - DATA_WIDTH){ram_dout[DATA_WIDTH-1]}}, ram_dout};
    if (sum_w[POT_WIDTH] != sum_w[POT_WIDTH-1])
      acc_add = sum_w[POT_WIDTH] ? {1'b1, {(POT_WIDTH-1){1'b0}}}
                                 : {1'b0, {(POT_WIDTH-1){1'b1}}};
    else
      acc_add = sum_w[POT_WIDTH-1:0];
    acc_new = t_spk ? acc_add : acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spk_q      <= '0;
      ram_addr   <= '0;
      in_cnt     <= '0;
      n_cnt      <= '0;
      a_v        <= 1'b0;
      t_v        <= 1'b0;
      t_spk      <= 1'b0;
      t_last     <= 1'b0;
      t_n        <= '0;
      acc        <= '0;
      busy       <= 1'b0;
      sum_valid  <= 1'b0;
      sum_neuron <= '0;
      sum_data   <= '0;
      done       <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      done      <= 1'b0;
      t_v       <= a_v;
      t_spk     <= spk_q[in_cnt];
      t_last    <= (in_cnt == IN_LAST);
      t_n       <= n_cnt;

      if (accept) begin
        spk_q    <= input_spikes;
        ram_addr <= BASE;
        in_cnt   <= '0;
        n_cnt    <= '0;
        a_v      <= 1'b1;
        busy     <= 1'b1;
      end else if (state == FETCH) begin
        ram_addr <= ram_addr + ADDR_WIDTH'(1);
        in_cnt   <= in_nxt;
        n_cnt    <= n_nxt;
      end else if (state == DRAIN) begin
        a_v <= 1'b0;
        if (drain_done) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end

      // The boundary word closes the neuron and the next neuron starts from zero.
      if (t_v) begin
        if (t_last) begin
          sum_data   <= acc_new;
          sum_neuron <= t_n;
          sum_valid  <= 1'b1;
          acc        <= '0;
        end else begin
          acc <= acc_new;
        end
      end
    end
  end

endmodule
